pwm_multi_generator: RTL and testbench
======================================

PWM_MULTI_GENERATOR -- requirements
Module: pwm_multi_generator

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs (1..16).
REQ-002 Parameter DUTY_WIDTH, default 8: duty and period-counter width in bits.
REQ-003 Parameter DIV_WIDTH, default 32: prescaler divide-ratio width in bits.
REQ-004 cclk  in  1: sole clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, asynchronous and active-high.
REQ-006 enable  in  1: 1 = counting, 0 = halted.
REQ-007 frequency_division  in  DIV_WIDTH: cclk cycles per counter tick; sampled live.
REQ-008 duty_cycle  in  CHANNELS*DUTY_WIDTH: packed duties; channel i at bits [i*DUTY_WIDTH +: DUTY_WIDTH].
REQ-009 mode  in  1: 0 = edge-aligned, 1 = center-aligned; captured with update.
REQ-010 update  in  1: one-cycle strobe; captures duty_cycle and mode into pending registers.
REQ-011 pwm  out  CHANNELS: registered PWM outputs.
REQ-012 period_start  out  1: registered one-cycle pulse at every period boundary.

Function
REQ-013 Prescaler: counts 0..frequency_division-1; tick asserted on the cycle the count equals frequency_division-1, count then returns to 0.
REQ-014 frequency_division of 0 or 1: tick every cycle.
REQ-015 Change of frequency_division mid-count: takes effect immediately; a prescaler count >= new limit-1 ticks on the next cycle and restarts at 0.
REQ-016 Edge-aligned: period counter cnt increments on tick, 0..MAX (MAX = 2^DUTY_WIDTH-1), wraps MAX->0; period = 2^DUTY_WIDTH ticks.
REQ-017 Center-aligned: cnt counts up 0..MAX then down MAX..0 on ticks, with no repeated value at either end; period = 2*MAX ticks.
REQ-018 Period boundary: the tick on which cnt transitions to 0 (wrap in edge mode, down-count reaching 0 in center mode).
REQ-019 Comparison: pwm[i] next = (cnt < active_duty[i]), unsigned, DUTY_WIDTH bits; pwm registered, one cycle after cnt.
REQ-020 Duty 0: pwm[i] constantly 0; duty MAX: high MAX of 2^DUTY_WIDTH counts (edge) or except at cnt = MAX (center).
REQ-021 update: pending_duty/pending_mode loaded on the edge update is high; repeated updates overwrite, last wins.
REQ-022 Shadow transfer: at each period boundary, active_duty/active_mode <= pending values; outputs never change duty mid-period (glitch-free).
REQ-023 update coincident with boundary: transfer uses pending values held before that edge; new values apply at the following boundary.
REQ-024 Mode change at transfer: cnt restarts at 0 counting up in the new mode.
REQ-025 period_start asserted the cycle after a boundary tick, for exactly one cycle.
REQ-026 enable = 0: prescaler and cnt held at 0, direction = up, pwm = 0, period_start = 0; update still loads pending.
REQ-027 enable rising: counting resumes from 0; pending values transferred to active on the first enabled cycle.

Reset
REQ-028 rst = 1 forces immediately: prescaler = 0, cnt = 0, direction up, pending/active duty = 0, pending/active mode = 0, pwm = 0, period_start = 0.
REQ-029 rst mid-period: outputs low within the same cycle; after release, operation restarts from 0 as after power-up.
REQ-030 First tick after rst release no earlier than frequency_division cycles after the first enabled edge.

Verification
REQ-031 freq_div=10, ch0 duty=7, mode 0, update, enable: pwm[0] high 70 cycles, low 2490 cycles per 2560-cycle period.
REQ-032 Duties {0,1,128,255}, freq_div=1: pwm = 0/1/128/255 high cycles per 256; period_start every 256 cycles.
REQ-033 Duty 64->192 via update mid-period: current period stays 64; next period after period_start is 192.
REQ-034 mode 1, freq_div=1, duty=100: period 510 cycles, pwm high 199 cycles centered on cnt=0.
REQ-035 update on the boundary cycle: old pending applied now, new value one period later.
REQ-036 rst asserted mid-period with pwm high: pwm = 0 immediately; after release with enable=1, duty=0 until a new update and boundary.

Source files
------------

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator: shared prescaler and period counter (edge- or
// center-aligned), per-channel compare with shadowed duty/mode registers.
module pwm_multi_generator #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DUTY_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 32
) (
    input  logic                           cclk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [DIV_WIDTH-1:0]           frequency_division,
    input  logic [CHANNELS*DUTY_WIDTH-1:0] duty_cycle,
    input  logic                           mode,
    input  logic                           update,
    output logic [CHANNELS-1:0]            pwm,
    output logic                           period_start
);

    localparam int unsigned DUTY_BUS = CHANNELS * DUTY_WIDTH;
    localparam logic [DUTY_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_WIDTH-1:0]  r_presc;
    logic [DUTY_WIDTH-1:0] r_cnt;
    dir_t                  r_dir;
    logic [DUTY_BUS-1:0]   r_pend_duty;
    logic                  r_pend_mode;
    logic [DUTY_BUS-1:0]   r_act_duty;
    logic                  r_act_mode;
    logic                  r_en_d;
    logic [CHANNELS-1:0]   r_pwm;
    logic                  r_period_start;

    logic [DIV_WIDTH-1:0]  w_limit;
    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_load;
    logic [DIV_WIDTH-1:0]  w_presc_next;
    logic [DUTY_WIDTH-1:0] w_cnt_next;
    dir_t                  w_dir_next;
    logic [CHANNELS-1:0]   w_pwm_next;

    // Divide ratios 0 and 1 both mean a tick every cycle; >= keeps a shrinking ratio safe.
    assign w_limit = (frequency_division > DIV_WIDTH'(1)) ?
                     (frequency_division - DIV_WIDTH'(1)) : '0;
    assign w_tick  = enable && (r_presc >= w_limit);

    // Period ends when cnt returns to 0: wrap in edge mode, end of down-slope in center mode.
    assign w_boundary = w_tick && ((r_dir == DIR_DOWN) ? (r_cnt == DUTY_WIDTH'(1))
                                                       : (!r_act_mode && (r_cnt == CNT_MAX)));
    assign w_load     = w_boundary || (enable && !r_en_d);

    always_comb begin
        w_presc_next = r_presc;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        if (!enable) begin
            w_presc_next = '0;
            w_cnt_next   = '0;
            w_dir_next   = DIR_UP;
        end else begin
            w_presc_next = w_tick ? '0 : (r_presc + DIV_WIDTH'(1));
            if (w_tick) begin
                if (w_boundary) begin
                    w_cnt_next = '0;
                    w_dir_next = DIR_UP;
                end else if (r_dir == DIR_DOWN) begin
                    w_cnt_next = r_cnt - DUTY_WIDTH'(1);
                end else if (r_act_mode && (r_cnt == CNT_MAX)) begin
                    w_cnt_next = CNT_MAX - DUTY_WIDTH'(1);
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + DUTY_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        w_pwm_next = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_pwm_next[i] = enable && (r_cnt < r_act_duty[i*DUTY_WIDTH +: DUTY_WIDTH]);
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_dir          <= DIR_UP;
            r_pend_duty    <= '0;
            r_pend_mode    <= 1'b0;
            r_act_duty     <= '0;
            r_act_mode     <= 1'b0;
            r_en_d         <= 1'b0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_presc        <= w_presc_next;
            r_cnt          <= w_cnt_next;
            r_dir          <= w_dir_next;
            r_en_d         <= enable;
            r_pwm          <= w_pwm_next;
            r_period_start <= w_boundary;
            if (update) begin
                r_pend_duty <= duty_cycle;
                r_pend_mode <= mode;
            end
            // Shadow transfer reads pending before this edge's update capture.
            if (w_load) begin
                r_act_duty <= r_pend_duty;
                r_act_mode <= r_pend_mode;
            end
        end
    end

    assign pwm          = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Scoreboard bench for pwm_multi_generator: per-period expected high counts are
// queued by stimulus and checked by a monitor at every period boundary.
module tb_pwm_multi_generator;

    localparam int unsigned CH = 4;

    logic        cclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] frequency_division = 32'd1;
    logic [31:0] duty_cycle = '0;
    logic        mode = 1'b0;
    logic        update = 1'b0;
    logic [3:0]  pwm;
    logic        period_start;

    typedef struct packed {
        logic [15:0]       len;
        logic [3:0][15:0]  hi;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int   m_len = 0;
    int   m_hi[CH];
    bit   m_armed = 0;
    bit   m_psd = 0;

    pwm_multi_generator #(.CHANNELS(4), .DUTY_WIDTH(8), .DIV_WIDTH(32)) dut (
        .cclk               (cclk),
        .rst                (rst),
        .enable             (enable),
        .frequency_division (frequency_division),
        .duty_cycle         (duty_cycle),
        .mode               (mode),
        .update             (update),
        .pwm                (pwm),
        .period_start       (period_start)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int len, input int h0, input int h1,
                                     input int h2, input int h3);
        exp_t e;
        e.len   = 16'(len);
        e.hi[0] = 16'(h0);
        e.hi[1] = 16'(h1);
        e.hi[2] = 16'(h2);
        e.hi[3] = 16'(h3);
        sb_q.push_back(e);
    endfunction

    // Window starts one cycle after period_start, where pwm reflects cnt = 0.
    always @(negedge cclk) begin
        exp_t e;
        if (m_psd && m_armed) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got unexpected period of %0d cycles, required none", m_len);
            end else begin
                e = sb_q.pop_front();
                check("period_len", m_len, int'(e.len));
                for (int i = 0; i < int'(CH); i++)
                    check($sformatf("high_cycles_ch%0d", i), m_hi[i], int'(e.hi[i]));
            end
        end
        if (m_psd) begin
            m_len   = 0;
            for (int i = 0; i < int'(CH); i++) m_hi[i] = 0;
            m_armed = 1;
        end
        if (m_armed) begin
            m_len++;
            for (int i = 0; i < int'(CH); i++) m_hi[i] += int'(pwm[i]);
        end
        m_psd = period_start;
        if (rst || !enable) begin
            m_armed = 0;
            m_psd   = 0;
        end
    end

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3, input bit md);
        duty_cycle = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        mode       = md;
        update     = 1'b1;
        @(negedge cclk);
        update     = 1'b0;
    endtask

    task automatic wait_ps(input int n, input int budget);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge cclk);
            cyc++;
            if (period_start) seen++;
        end
        check("wait_period_start", seen, n);
    endtask

    task automatic first_ps_latency(input int expected);
        int cyc;
        cyc = 0;
        enable = 1'b1;
        do begin
            @(negedge cclk);
            cyc++;
        end while (!period_start && cyc < expected + 100);
        check("first_period_latency", cyc, expected);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (4) @(negedge cclk);
    endtask

    initial begin
        for (int i = 0; i < int'(CH); i++) m_hi[i] = 0;
        repeat (3) @(negedge cclk);
        check("reset_pwm", pwm, 0);
        check("reset_period_start", period_start, 0);
        rst = 1'b0;
        @(negedge cclk);

        // Slow prescaler, single active channel; update while halted.
        frequency_division = 32'd10;
        set_duty(7, 0, 0, 0, 1'b0);
        repeat (3) @(negedge cclk);
        check("halted_pwm", pwm, 0);
        check("halted_period_start", period_start, 0);
        push_exp(2560, 70, 0, 0, 0);
        push_exp(2560, 70, 0, 0, 0);
        first_ps_latency(2560);
        wait_ps(2, 6000);
        @(negedge cclk);
        stop_run();

        // Duty extremes, edge-aligned, tick every cycle.
        frequency_division = 32'd1;
        set_duty(0, 1, 128, 255, 1'b0);
        for (int k = 0; k < 3; k++) push_exp(256, 0, 1, 128, 255);
        first_ps_latency(256);
        wait_ps(3, 1000);
        @(negedge cclk);
        stop_run();

        // Mid-period duty change must wait for the next boundary.
        frequency_division = 32'd0;
        set_duty(64, 10, 200, 255, 1'b0);
        push_exp(256, 64, 10, 200, 255);
        push_exp(256, 64, 10, 200, 255);
        push_exp(256, 192, 20, 0, 128);
        enable = 1'b1;
        wait_ps(2, 1000);
        repeat (100) @(negedge cclk);
        set_duty(192, 20, 0, 128, 1'b0);
        wait_ps(2, 1000);
        @(negedge cclk);
        stop_run();

        // Center-aligned: 510-cycle period, 2*d-1 high cycles.
        frequency_division = 32'd1;
        set_duty(100, 0, 1, 255, 1'b1);
        push_exp(510, 199, 0, 1, 509);
        push_exp(510, 199, 0, 1, 509);
        enable = 1'b1;
        wait_ps(3, 3000);
        @(negedge cclk);
        stop_run();

        // Update coincident with the boundary edge.
        set_duty(50, 50, 50, 50, 1'b0);
        push_exp(256, 50, 50, 50, 50);
        push_exp(256, 100, 100, 100, 100);
        push_exp(256, 200, 200, 200, 200);
        enable = 1'b1;
        wait_ps(1, 1000);
        repeat (10) @(negedge cclk);
        set_duty(100, 100, 100, 100, 1'b0);
        repeat (244) @(negedge cclk);
        duty_cycle = {4{8'd200}};
        update     = 1'b1;
        @(negedge cclk);
        update     = 1'b0;
        check("ps_on_boundary", period_start, 1);
        wait_ps(2, 1000);
        @(negedge cclk);
        stop_run();

        // Reset mid-period with pwm high; active duty returns to 0.
        set_duty(200, 200, 200, 200, 1'b0);
        enable = 1'b1;
        wait_ps(1, 1000);
        repeat (5) @(negedge cclk);
        check("pre_reset_pwm", pwm, 15);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pwm", pwm, 0);
        check("async_reset_period_start", period_start, 0);
        repeat (3) @(negedge cclk);
        rst = 1'b0;
        push_exp(256, 0, 0, 0, 0);
        push_exp(256, 0, 0, 0, 0);
        push_exp(256, 77, 0, 255, 1);
        wait_ps(2, 1000);
        repeat (20) @(negedge cclk);
        set_duty(77, 0, 255, 1, 1'b0);
        wait_ps(2, 1000);
        @(negedge cclk);
        stop_run();

        check("scoreboard_leftover", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
